// File: rtl/rv_loader_pkg.sv
// rv_loader_pkg: state encoding and defaults shared by the instruction-memory loader.
package rv_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT_LO,
        CNT_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;

    localparam logic [7:0] LOADER_MAGIC_DEFAULT = 8'hA5;

endpackage

// File: rtl/loader_word_packer.sv
// loader_word_packer: gathers little-endian bytes and presents the full word as the fourth byte arrives.
module loader_word_packer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    input  logic [1:0]  byte_idx_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [23:0] wbuf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wbuf_q <= '0;
        end else if (byte_valid_i) begin
            if (byte_idx_i == 2'd0) wbuf_q[7:0]   <= byte_i;
            if (byte_idx_i == 2'd1) wbuf_q[15:8]  <= byte_i;
            if (byte_idx_i == 2'd2) wbuf_q[23:16] <= byte_i;
        end
    end

    // The top byte is never stored: it is forwarded straight into the word being written.
    assign word_o       = {byte_i, wbuf_q};
    assign word_valid_o = byte_valid_i && (byte_idx_i == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a framed byte stream into instruction memory as word writes, holding the core until done.
// Build with IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import rv_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [7:0]  MAGIC       = LOADER_MAGIC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_hold,
    output logic        load_done,
    output logic        load_err
);

    localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);
`ifdef IMEM_LOADER_CSUM_EN
    localparam loader_state_t END_ST = CSUM;
`else
    localparam loader_state_t END_ST = DONE;
`endif

    loader_state_t state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic [15:0]   word_idx_q;
    logic [1:0]    byte_idx_q;
    logic [31:0]   addr_q, wdata_q, word;
    logic          in_ready_q, we_q, we_d, core_hold_q, load_done_q, load_err_q;
    logic          fire, last_word, word_valid;

    assign fire      = in_valid && in_ready_q;
    assign count_d   = {in_data, count_q[7:0]};
    assign last_word = (17'(word_idx_q) + 17'd1) == {1'b0, count_q};

    loader_word_packer u_packer (
        .clk_i       (clk),
        .rst_ni      (rst),
        .byte_valid_i(fire && state_q == DATA),
        .byte_i      (in_data),
        .byte_idx_i  (byte_idx_q),
        .word_o      (word),
        .word_valid_o(word_valid)
    );

`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            csum_q <= '0;
        else if (state_d == CNT_LO)
            csum_q <= '0;
        else if (fire && (state_q inside {CNT_LO, CNT_HI, DATA}))
            csum_q <= csum_q ^ in_data;
    end
`endif

    always_comb begin
        state_d = state_q;
        we_d    = word_valid;
        case (state_q)
            IDLE:   if (fire && in_data == MAGIC) state_d = CNT_LO;
            CNT_LO: if (fire) state_d = CNT_HI;
            CNT_HI: if (fire) state_d = ({1'b0, count_d} > DEPTH_L) ? ERROR :
                                        (count_d == 16'd0)          ? END_ST : DATA;
            // The word write occupies its own slot; the frame advances once it retires.
            DATA:   if (we_q) state_d = last_word ? END_ST : DATA;
`ifdef IMEM_LOADER_CSUM_EN
            CSUM:   if (fire) state_d = (in_data == csum_q) ? DONE : ERROR;
`endif
            DONE:   if (fire && in_data == MAGIC) state_d = CNT_LO;
            ERROR:  if (fire && in_data == MAGIC) state_d = CNT_LO;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            addr_q      <= BASE_ADDR;
            wdata_q     <= '0;
            in_ready_q  <= 1'b0;
            we_q        <= 1'b0;
            core_hold_q <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            in_ready_q  <= !we_d;
            core_hold_q <= state_d != DONE;
            load_done_q <= state_d == DONE;
            load_err_q  <= state_d == ERROR;
            if (fire && state_q == CNT_LO) count_q[7:0]  <= in_data;
            if (fire && state_q == CNT_HI) count_q[15:8] <= in_data;
            if (fire && state_q == CNT_HI) byte_idx_q    <= '0;
            if (fire && state_q == DATA)   byte_idx_q    <= byte_idx_q + 2'd1;
            if (we_d) begin
                wdata_q <= word;
                addr_q  <= BASE_ADDR + {14'd0, word_idx_q, 2'b00};
            end
            if (state_d == CNT_LO)
                word_idx_q <= '0;
            else if (state_q == DATA && we_q)
                word_idx_q <= word_idx_q + 16'd1;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_hold  = core_hold_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of framing, word writes, core hold and reset abort for imem_loader.
// Checksum bytes are only put on the wire when built with IMEM_LOADER_CSUM_EN.
module tb_imem_loader;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data  = 8'h00;
    logic        in_ready, imem_we, core_hold, load_done, load_err;
    logic [31:0] imem_addr, imem_wdata;
    int          errors  = 0;
    int          checks  = 0;
    int          rdy_bad = 0;
    bit          rdy_chk = 1'b0;
    logic [31:0] waddr[$];
    logic [31:0] wdat[$];

    imem_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_hold (core_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    // Log every write strobe and flag any cycle where in_ready is not the inverse of the write slot.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            waddr.push_back(imem_addr);
            wdat.push_back(imem_wdata);
        end
        if (rdy_chk && rst && (in_ready !== ~imem_we)) rdy_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) check("rdy_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[7:0]);
        send(w[15:8]);
        send(w[23:16]);
        send(w[31:24]);
    endtask

    task automatic close_frame(input logic [7:0] cs);
`ifdef IMEM_LOADER_CSUM_EN
        send(cs);
`else
        in_data = cs;
        tick();
`endif
    endtask

    task automatic clear_log();
        waddr.delete();
        wdat.delete();
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_hold", 32'(core_hold), 32'd1);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("ready_after_rst", 32'(in_ready), 32'd1);
        rdy_chk = 1'b1;

        // Garbage in IDLE, then a 2-word frame
        send(8'h00);
        send(8'hFF);
        check("idle_hold", 32'(core_hold), 32'd1);
        check("idle_done", 32'(load_done), 32'd0);
        send(8'hA5);
        send(8'h02);
        send(8'h00);
        send_word(32'h0050_0113);
        send_word(32'h0000_0063);
        check("a_slot_we", 32'(imem_we), 32'd1);
        check("a_slot_ready", 32'(in_ready), 32'd0);
        check("a_slot_hold", 32'(core_hold), 32'd1);
        close_frame(8'h23);
        check("a_hold", 32'(core_hold), 32'd0);
        check("a_done", 32'(load_done), 32'd1);
        check("a_err", 32'(load_err), 32'd0);
        check("a_nwrites", 32'(waddr.size()), 32'd2);
        check("a_addr0", waddr[0], 32'h0);
        check("a_data0", wdat[0], 32'h0050_0113);
        check("a_addr1", waddr[1], 32'h4);
        check("a_data1", wdat[1], 32'h0000_0063);
        clear_log();

        // Reload with count 0x0101, one past capacity
        send(8'hA5);
        check("big_hold_magic", 32'(core_hold), 32'd1);
        check("big_done_magic", 32'(load_done), 32'd0);
        send(8'h01);
        send(8'h01);
        check("big_err", 32'(load_err), 32'd1);
        check("big_done", 32'(load_done), 32'd0);
        check("big_hold", 32'(core_hold), 32'd1);
        check("big_nwrites", 32'(waddr.size()), 32'd0);

`ifdef IMEM_LOADER_CSUM_EN
        // Valid frame with inverted checksum
        send(8'hA5);
        check("bad_err_clear", 32'(load_err), 32'd0);
        send(8'h02);
        send(8'h00);
        send_word(32'h0050_0113);
        send_word(32'h0000_0063);
        send(8'hDC);
        check("bad_err", 32'(load_err), 32'd1);
        check("bad_done", 32'(load_done), 32'd0);
        check("bad_hold", 32'(core_hold), 32'd1);
        check("bad_nwrites", 32'(waddr.size()), 32'd2);
        clear_log();
`endif

        // Garbage in ERROR, then a 1-word frame with idle cycles between bytes
        send(8'h00);
        send(8'hFF);
        check("err_sticky", 32'(load_err), 32'd1);
        send(8'hA5);
        check("err_clear", 32'(load_err), 32'd0);
        tick();
        send(8'h01);
        tick();
        send(8'h00);
        tick();
        send(8'h78);
        tick();
        send(8'h56);
        tick();
        send(8'h34);
        tick();
        send(8'h12);
        check("slow_slot_we", 32'(imem_we), 32'd1);
        tick();
        close_frame(8'h09);
        check("slow_done", 32'(load_done), 32'd1);
        check("slow_nwrites", 32'(waddr.size()), 32'd1);
        check("slow_addr", waddr[0], 32'h0);
        check("slow_data", wdat[0], 32'h1234_5678);
        clear_log();

        // Reload from DONE overwrites word 0
        send(8'hA5);
        check("rl_hold", 32'(core_hold), 32'd1);
        check("rl_done", 32'(load_done), 32'd0);
        send(8'h01);
        send(8'h00);
        send_word(32'hDEAD_BEEF);
        close_frame(8'h23);
        check("rl_done_again", 32'(load_done), 32'd1);
        check("rl_hold_low", 32'(core_hold), 32'd0);
        check("rl_nwrites", 32'(waddr.size()), 32'd1);
        check("rl_addr", waddr[0], 32'h0);
        check("rl_data", wdat[0], 32'hDEAD_BEEF);
        clear_log();

        // Zero-length frame
        send(8'hA5);
        send(8'h00);
        send(8'h00);
        close_frame(8'h00);
        check("zero_done", 32'(load_done), 32'd1);
        check("zero_hold", 32'(core_hold), 32'd0);
        check("zero_nwrites", 32'(waddr.size()), 32'd0);

        // Reset after two data bytes, then a full frame
        send(8'hA5);
        send(8'h01);
        send(8'h00);
        send(8'h11);
        send(8'h22);
        rdy_chk = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_we", 32'(imem_we), 32'd0);
        check("mid_rst_hold", 32'(core_hold), 32'd1);
        check("mid_rst_done", 32'(load_done), 32'd0);
        check("mid_rst_addr", imem_addr, 32'h0);
        check("mid_rst_wdata", imem_wdata, 32'h0);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        rdy_chk = 1'b1;
        check("mid_rst_nwrites", 32'(waddr.size()), 32'd0);
        send(8'hA5);
        send(8'h01);
        send(8'h00);
        send_word(32'h1122_3344);
        close_frame(8'h45);
        check("post_rst_done", 32'(load_done), 32'd1);
        check("post_rst_hold", 32'(core_hold), 32'd0);
        check("post_rst_nwrites", 32'(waddr.size()), 32'd1);
        check("post_rst_addr", waddr[0], 32'h0);
        check("post_rst_data", wdat[0], 32'h1122_3344);

        check("ready_protocol", 32'(rdy_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
